// File: rtl/or16_result_fifo.sv
// First-word-fall-through result buffer behind the 16-bit OR unit; stores a zero flag per entry.
// Optional per-entry parity and out_parity port under OR16_PARITY_EN.
module or16_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
`ifdef OR16_PARITY_EN
  output logic             out_parity,
`endif
  output logic [AW:0]      count
);

`ifdef OR16_PARITY_EN
  localparam int unsigned EW = WIDTH + 2;
`else
  localparam int unsigned EW = WIDTH + 1;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Handshake flags derive from count alone, so they never depend on in_valid/out_ready.
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~rst;
  assign pop       = out_valid & out_ready & ~rst;

`ifdef OR16_PARITY_EN
  assign wr_entry = {^in_data, (in_data == '0), in_data};
`else
  assign wr_entry = {(in_data == '0), in_data};
`endif

  // Storage is intentionally not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign head = mem[rd_ptr];

  // Head outputs are forced to zero while empty.
  always_comb begin
    out_data = '0;
    out_zero = 1'b0;
    if (out_valid) begin
      out_data = head[WIDTH-1:0];
      out_zero = head[WIDTH];
    end
  end

`ifdef OR16_PARITY_EN
  assign out_parity = out_valid ? head[WIDTH+1] : 1'b0;
`endif

endmodule

// File: tb/tb_or16_result_fifo.sv
// Directed self-checking bench for or16_result_fifo; parity checks compile in with OR16_PARITY_EN.
module tb_or16_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic [2:0]  count;
`ifdef OR16_PARITY_EN
  logic        out_parity;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  or16_result_fifo #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
`ifdef OR16_PARITY_EN
    .out_parity(out_parity),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic [15:0] d, input logic z);
    chk({tag, "_valid"}, 16'(out_valid), 16'h1);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_zero"},  16'(out_zero), 16'(z));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_q [$];
    logic [15:0] w;

    // Reset held two cycles with a pending push
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    tick(); tick();
    chk("rst_count", 16'(count), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_zero", 16'(out_zero), 16'h0);
`ifdef OR16_PARITY_EN
    chk("rst_out_parity", 16'(out_parity), 16'h0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_count", 16'(count), 16'h0);

    // Single push then pop
    in_valid = 1'b1; in_data = 16'hA5A0;
    tick();
    in_valid = 1'b0;
    chk_head("single", 16'hA5A0, 1'b0);
    chk("single_count", 16'(count), 16'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", 16'(count), 16'h0);
    chk("single_pop_valid", 16'(out_valid), 16'h0);
    chk("single_pop_data", out_data, 16'h0);

    // Fill to full, then an attempted fifth push
    exp_q = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
    foreach (exp_q[i]) begin
      in_valid = 1'b1; in_data = exp_q[i];
      tick();
      if (i == 0) chk_head("first_zero", 16'h0000, 1'b1);
    end
    chk("full_count", 16'(count), 16'h4);
    chk("full_in_ready", 16'(in_ready), 16'h0);
    in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk("full_reject_count", 16'(count), 16'h4);
    chk_head("full_stall_head", 16'h0000, 1'b1);
    out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk_head("drain", w, w == 16'h0);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 16'(count), 16'h0);
    chk("drain_valid", 16'(out_valid), 16'h0);

    // Simultaneous push+pop at count=2
    in_valid = 1'b1;
    in_data = 16'hAAAA; tick();
    in_data = 16'hBBBB; tick();
    chk("sim2_pre_count", 16'(count), 16'h2);
    in_data = 16'hCCCC; out_ready = 1'b1;
    tick();
    chk("sim2_count", 16'(count), 16'h2);
    chk_head("sim2_head", 16'hBBBB, 1'b0);
    out_ready = 1'b0;
    in_data = 16'hDDDD; tick();
    in_data = 16'hEEEE; tick();
    chk("sim4_pre_count", 16'(count), 16'h4);

    // At full, pop with in_valid: incoming word dropped
    in_data = 16'h9999; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim4_count", 16'(count), 16'h3);
    chk("sim4_in_ready", 16'(in_ready), 16'h1);
    exp_q = '{16'hCCCC, 16'hDDDD, 16'hEEEE};
    while (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk_head("sim4_drain", w, 1'b0);
      tick();
    end
    out_ready = 1'b0;
    chk("sim4_empty_count", 16'(count), 16'h0);

    // Ten push/pop pairs walking pointers through several wraps
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'(32'd1 << i);
      tick();
      in_valid = 1'b0;
      chk_head("wrap", 16'(32'd1 << i), 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("wrap_count", 16'(count), 16'h0);

`ifdef OR16_PARITY_EN
    in_valid = 1'b1; in_data = 16'h0007;
    tick();
    in_valid = 1'b0;
    chk("parity_odd", 16'(out_parity), 16'h1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("parity_empty", 16'(out_parity), 16'h0);
    in_valid = 1'b1; in_data = 16'h0003;
    tick();
    in_valid = 1'b0;
    chk("parity_even", 16'(out_parity), 16'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

    // Reset mid-operation discards contents
    in_valid = 1'b1;
    in_data = 16'h0011; tick();
    in_data = 16'h0022; tick();
    in_data = 16'h0033; tick();
    in_valid = 1'b0;
    chk("midrst_pre_count", 16'(count), 16'h3);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("midrst_count", 16'(count), 16'h0);
    chk("midrst_valid", 16'(out_valid), 16'h0);
    chk("midrst_data", out_data, 16'h0);
    in_valid = 1'b1; in_data = 16'h0044;
    tick();
    in_valid = 1'b0;
    chk_head("midrst_after", 16'h0044, 1'b0);
    chk("midrst_after_count", 16'(count), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
